key_process_array: RTL and testbench

//  Parametrised multi-channel successor to the single-key debouncer. Synchronises N raw key inputs
//  and debounces each one independently. Per channel it produces a stable level plus one-cycle

---
 rtl/key_process_pkg.sv | 19 +
 rtl/key_channel.sv | 186 ++++++++++++++++++
 rtl/key_process_array.sv | 51 +++++
 tb/tb_key_process_array.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_process_pkg.sv
// ----------------------------------------------------------------------------
// key_process_pkg
//   Shared types and helpers for the key_process_array slice.
//   - kp_state_t : per-channel key state (released / held / long reported)
//   - kp_cnt_w() : bit width needed for a counter that must hold 0..max_val
// ----------------------------------------------------------------------------
package key_process_pkg;

    typedef enum logic [1:0] {
        KP_IDLE = 2'd0,
        KP_HELD = 2'd1,
        KP_LONG = 2'd2
    } kp_state_t;

    function automatic int kp_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// ----------------------------------------------------------------------------
// key_channel
//   One key: 2-FF synchroniser, polarity normalisation, debounce counter,
//   IDLE/HELD/LONG state machine with hold and (optional) repeat counters.
//   Build option: define KEY_REPEAT_EN to generate the auto-repeat logic;
//   otherwise key_repeat is tied low and LONG is a terminal hold state.
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   key_raw      raw asynchronous pin
//   key_level    debounced level, 1 = pressed
//   key_press    1-cycle pulse on accepted press
//   key_release  1-cycle pulse on accepted release
//   key_long     1-cycle pulse when the hold reaches LONG_CYC
//   key_repeat   1-cycle pulses every REPEAT_CYC while in LONG
// ----------------------------------------------------------------------------
module key_channel
    import key_process_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 100,
    parameter int LONG_CYC     = 50000,
    parameter int REPEAT_CYC   = 10000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int DW = kp_cnt_w(DEBOUNCE_CYC);
    localparam int HW = kp_cnt_w((LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
    localparam logic          IDLE_LVL  = (ACTIVE_LOW != 0);

    logic            sync_p0, sync_p1, key_s;
    logic [DW-1:0]   db_cnt;
    logic            db_fire, acc_press, acc_release;
    kp_state_t       state, state_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic            press_d, release_d, long_d, repeat_d;

    // Stage p0/p1: synchroniser, reset to the released pin level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= IDLE_LVL;
            sync_p1 <= IDLE_LVL;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign key_s = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

    // Debounce: level flips on the DEBOUNCE_CYC-th consecutive differing sample
    assign db_fire     = (key_s != key_level) && (db_cnt == DB_LAST);
    assign acc_press   = db_fire &  key_s;
    assign acc_release = db_fire & ~key_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt    <= '0;
            key_level <= 1'b0;
        end else if (key_s == key_level) begin
            db_cnt    <= '0;
        end else if (db_fire) begin
            db_cnt    <= '0;
            key_level <= key_s;
        end else begin
            db_cnt    <= db_cnt + 1'b1;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_CYC - 1);
    logic [HW-1:0] rep_cnt, rep_nxt;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= KP_IDLE;
            hold_cnt <= '0;
`ifdef KEY_REPEAT_EN
            rep_cnt  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
`ifdef KEY_REPEAT_EN
            rep_cnt  <= rep_nxt;
`endif
        end
    end

    // Next-state logic; an accepted release always takes priority
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
`ifdef KEY_REPEAT_EN
        rep_nxt   = rep_cnt;
`endif
        case (state)
            KP_IDLE: begin
                if (acc_press) begin
                    state_nxt = KP_HELD;
                    hold_nxt  = '0;
                end
            end
            KP_HELD: begin
                if (acc_release) begin
                    state_nxt = KP_IDLE;
                    hold_nxt  = '0;
                end else if (hold_cnt == LONG_LAST) begin
                    state_nxt = KP_LONG;
                    hold_nxt  = '0;
`ifdef KEY_REPEAT_EN
                    rep_nxt   = '0;
`endif
                end else begin
                    hold_nxt  = hold_cnt + 1'b1;
                end
            end
            KP_LONG: begin
                if (acc_release) begin
                    state_nxt = KP_IDLE;
                    hold_nxt  = '0;
`ifdef KEY_REPEAT_EN
                    rep_nxt   = '0;
                end else if (rep_cnt == REP_LAST) begin
                    rep_nxt   = '0;
                end else begin
                    rep_nxt   = rep_cnt + 1'b1;
`endif
                end
            end
            default: begin
                state_nxt = KP_IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    // Output decode; pulses are registered so they line up with key_level
    always_comb begin
        press_d   = (state == KP_IDLE) && acc_press;
        release_d = (state != KP_IDLE) && acc_release;
        long_d    = (state == KP_HELD) && !acc_release && (hold_cnt == LONG_LAST);
`ifdef KEY_REPEAT_EN
        repeat_d  = (state == KP_LONG) && !acc_release && (rep_cnt == REP_LAST);
`else
        repeat_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= press_d;
            key_release <= release_d;
            key_long    <= long_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_repeat <= 1'b0;
        end else begin
            key_repeat <= repeat_d;
        end
    end
`else
    assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_process_array.sv
// ----------------------------------------------------------------------------
// key_process_array
//   N_KEYS independent debounced key channels (see key_channel).
//   Build option: KEY_REPEAT_EN enables auto-repeat pulses in every channel.
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   key_raw[N]      raw key pins
//   key_level[N]    debounced levels (1 = pressed)
//   key_press[N]    press pulses
//   key_release[N]  release pulses
//   key_long[N]     long-press pulses
//   key_repeat[N]   auto-repeat pulses (0 without KEY_REPEAT_EN)
// ----------------------------------------------------------------------------
module key_process_array
    import key_process_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int DEBOUNCE_CYC = 100,
    parameter int LONG_CYC     = 50000,
    parameter int REPEAT_CYC   = 10000,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i]),
            .key_repeat  (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_process_array.sv
module tb_key_process_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_raw;
    logic [1:0] key_level, key_press, key_release, key_long, key_repeat;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mon_ch = 0;
    int pq[$];   // press cycles on mon_ch
    int rq[$];   // release cycles on mon_ch
    int lq[$];   // long cycles on mon_ch
    int tq[$];   // repeat cycles on mon_ch
    int bq[$];   // cycles where both channels pressed together
    int aq[$];   // cycles with any release pulse

    key_process_array #(
        .N_KEYS       (2),
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .REPEAT_CYC   (8),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (key_press[mon_ch])   pq.push_back(cyc);
        if (key_release[mon_ch]) rq.push_back(cyc);
        if (key_long[mon_ch])    lq.push_back(cyc);
        if (key_repeat[mon_ch])  tq.push_back(cyc);
        if (key_press == 2'b11)  bq.push_back(cyc);
        if (key_release != 2'b00) aq.push_back(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_q();
        pq.delete(); rq.delete(); lq.delete(); tq.delete(); bq.delete(); aq.delete();
    endtask

    task automatic test_reset();
        int t0;
        rst = 1'b1;
        key_raw = 2'b00;
        run(3);
        n_cmp++;
        if ({key_level, key_press, key_release, key_long, key_repeat} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {key_level, key_press, key_release, key_long, key_repeat});
        end
        mon_ch = 0;
        clear_q();
        rst = 1'b0;
        t0 = cyc;
        run(10);
        n_cmp++;
        if (pq.size() != 1 || pq[0] != t0 + 6) begin
            n_bad++;
            $display("FAIL reset_first_press: count %0d first %0d want 1 at %0d", pq.size(), (pq.size() > 0) ? pq[0] : -1, t0 + 6);
        end
        n_cmp++;
        if (key_level !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_level_after_press: got %b want 11", key_level);
        end
        key_raw = 2'b11;
        t0 = cyc;
        run(10);
        n_cmp++;
        if (rq.size() != 1 || rq[0] != t0 + 6) begin
            n_bad++;
            $display("FAIL reset_release: count %0d first %0d want 1 at %0d", rq.size(), (rq.size() > 0) ? rq[0] : -1, t0 + 6);
        end
        n_cmp++;
        if (key_level !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_level_after_release: got %b want 00", key_level);
        end
    endtask

    task automatic test_bounce();
        int t0;
        mon_ch = 0;
        clear_q();
        t0 = 0;
        for (int i = 0; i < 15; i++) begin
            key_raw[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
            if (i == 14) t0 = cyc;
            tick();
            tick();
        end
        run(10);
        n_cmp++;
        if (pq.size() != 1 || pq[0] != t0 + 6) begin
            n_bad++;
            $display("FAIL bounce_press: count %0d first %0d want 1 at %0d", pq.size(), (pq.size() > 0) ? pq[0] : -1, t0 + 6);
        end
        n_cmp++;
        if (rq.size() != 0) begin
            n_bad++;
            $display("FAIL bounce_no_release: count %0d want 0", rq.size());
        end
        key_raw[0] = 1'b1;
        run(10);
    endtask

    task automatic test_short_press();
        int t0;
        mon_ch = 0;
        clear_q();
        key_raw[0] = 1'b0;
        t0 = cyc;
        run(12);
        key_raw[0] = 1'b1;
        run(12);
        n_cmp++;
        if (pq.size() != 1 || pq[0] != t0 + 6) begin
            n_bad++;
            $display("FAIL short_press: count %0d first %0d want 1 at %0d", pq.size(), (pq.size() > 0) ? pq[0] : -1, t0 + 6);
        end
        n_cmp++;
        if (rq.size() != 1 || rq[0] != t0 + 18) begin
            n_bad++;
            $display("FAIL short_release: count %0d first %0d want 1 at %0d", rq.size(), (rq.size() > 0) ? rq[0] : -1, t0 + 18);
        end
        n_cmp++;
        if (lq.size() != 0 || tq.size() != 0) begin
            n_bad++;
            $display("FAIL short_no_long: long %0d repeat %0d want 0 0", lq.size(), tq.size());
        end
    endtask

    task automatic test_long_repeat();
        int t0;
        int exp_rep[$];
        mon_ch = 1;
        clear_q();
        key_raw[1] = 1'b0;
        t0 = cyc;
        run(60);
        key_raw[1] = 1'b1;
        run(10);
        n_cmp++;
        if (pq.size() != 1 || pq[0] != t0 + 6) begin
            n_bad++;
            $display("FAIL long_press: count %0d first %0d want 1 at %0d", pq.size(), (pq.size() > 0) ? pq[0] : -1, t0 + 6);
        end
        n_cmp++;
        if (lq.size() != 1 || lq[0] != t0 + 26) begin
            n_bad++;
            $display("FAIL long_pulse: count %0d first %0d want 1 at %0d", lq.size(), (lq.size() > 0) ? lq[0] : -1, t0 + 26);
        end
        n_cmp++;
        if (rq.size() != 1 || rq[0] != t0 + 66) begin
            n_bad++;
            $display("FAIL long_release: count %0d first %0d want 1 at %0d", rq.size(), (rq.size() > 0) ? rq[0] : -1, t0 + 66);
        end
`ifdef KEY_REPEAT_EN
        // press+28, +36, +44, +52; press+60 coincides with the release and is suppressed
        exp_rep = '{t0 + 34, t0 + 42, t0 + 50, t0 + 58};
`endif
        n_cmp++;
        if (tq.size() != exp_rep.size()) begin
            n_bad++;
            $display("FAIL repeat_count: got %0d want %0d", tq.size(), exp_rep.size());
        end else begin
            foreach (exp_rep[k]) begin
                n_cmp++;
                if (tq[k] != exp_rep[k]) begin
                    n_bad++;
                    $display("FAIL repeat_time_%0d: got %0d want %0d", k, tq[k], exp_rep[k]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        mon_ch = 0;
        clear_q();
        key_raw[0] = 1'b0;
        run(3);
        key_raw[0] = 1'b1;
        run(12);
        n_cmp++;
        if (pq.size() + rq.size() + lq.size() + tq.size() != 0) begin
            n_bad++;
            $display("FAIL glitch_activity: press %0d release %0d long %0d repeat %0d want all 0", pq.size(), rq.size(), lq.size(), tq.size());
        end
        n_cmp++;
        if (key_level[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL glitch_level: got %b want 0", key_level[0]);
        end
    endtask

    task automatic test_concurrency_reset();
        int t0;
        mon_ch = 0;
        clear_q();
        key_raw = 2'b00;
        t0 = cyc;
        run(11);
        n_cmp++;
        if (bq.size() != 1 || bq[0] != t0 + 6) begin
            n_bad++;
            $display("FAIL concurrent_press: count %0d first %0d want 1 at %0d", bq.size(), (bq.size() > 0) ? bq[0] : -1, t0 + 6);
        end
        n_cmp++;
        if (key_level !== 2'b11) begin
            n_bad++;
            $display("FAIL concurrent_level: got %b want 11", key_level);
        end
        clear_q();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({key_level, key_press, key_release, key_long, key_repeat} !== 10'b0) begin
            n_bad++;
            $display("FAIL midhold_reset_clear: got %b want 0", {key_level, key_press, key_release, key_long, key_repeat});
        end
        run(3);
        rst = 1'b0;
        t0 = cyc;
        run(10);
        n_cmp++;
        if (aq.size() != 0) begin
            n_bad++;
            $display("FAIL midhold_no_release: count %0d want 0", aq.size());
        end
        n_cmp++;
        if (bq.size() != 1 || bq[0] != t0 + 6) begin
            n_bad++;
            $display("FAIL post_reset_press: count %0d first %0d want 1 at %0d", bq.size(), (bq.size() > 0) ? bq[0] : -1, t0 + 6);
        end
        key_raw = 2'b11;
        run(10);
    endtask

    initial begin
        rst = 1'b1;
        key_raw = 2'b11;
        test_reset();
        test_bounce();
        test_short_press();
        test_long_repeat();
        test_glitch();
        test_concurrency_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
